spike_dispatch: RTL and testbench

SPIKE_DISPATCH -- requirements
Module: spike_dispatch

---
 rtl/spike_dispatch_pkg.sv | 23 ++
 rtl/spike_dispatch_sat_counter.sv | 34 +++
 rtl/spike_dispatch.sv | 107 ++++++++++
 tb/tb_spike_dispatch.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_dispatch_pkg.sv
// Shared types for the spike dispatcher: FSM states and the AER event record.
// Imported by the dispatcher RTL and its bench.
package spike_dispatch_pkg;

  localparam int TICK_W     = 8;
  localparam int AER_ADDR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_POP     = 3'd2,
    S_LATCH   = 3'd3,
    S_REQ     = 3'd4,
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  typedef struct packed {
    logic [AER_ADDR_W-1:0] addr;
    logic [TICK_W-1:0]     tick;
  } aer_evt_t;

endpackage

// File: rtl/spike_dispatch_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_dispatch.sv
// Drains the spike FIFO for one tick and emits each spike as a
// four-phase AER event stamped with the captured tick.
module spike_dispatch
  import spike_dispatch_pkg::*;
#(
  parameter int N     = 256,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(N)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start_i,
  input  logic [TICK_W-1:0] tick_i,
  input  logic              next_tick_i,
  input  logic              spikecore_done_i,
  input  logic              FIFO_empty_i,
  output logic              FIFO_r_en_o,
  input  logic [AW-1:0]     FIFO_r_data_i,
  output logic              aer_req_o,
  output logic [AW-1:0]     aer_addr_o,
  output logic [TICK_W-1:0] aer_tick_o,
  input  logic              aer_ack_i,
  output logic [CNT_W-1:0]  event_count_o,
  output logic              dispatch_done_o
);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              cnt_clr, cnt_inc;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tick_d  = tick_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WAIT;
          tick_d  = tick_i;
          cnt_clr = 1'b1;
        end
      end
      // FIFO drains before done is honoured
      S_WAIT: begin
        if (!FIFO_empty_i) begin
          state_d = S_POP;
        end else if (spikecore_done_i) begin
          state_d = S_DONE;
        end
      end
      S_POP: state_d = S_LATCH;
      S_LATCH: begin
        addr_d  = FIFO_r_data_i;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (aer_ack_i) begin
          state_d = S_RELEASE;
          cnt_inc = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!aer_ack_i) begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (next_tick_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tick_q  <= tick_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (CLK),
    .rst_n(RSTN),
    .clr_i(cnt_clr),
    .inc_i(cnt_inc),
    .cnt_o(event_count_o)
  );

  assign FIFO_r_en_o     = (state_q == S_POP);
  assign aer_req_o       = (state_q == S_REQ);
  assign dispatch_done_o = (state_q == S_DONE);
  assign aer_addr_o      = addr_q;
  assign aer_tick_o      = tick_q;

endmodule

// File: tb/tb_spike_dispatch.sv
// Scoreboard bench for spike_dispatch: FIFO and AER responder models,
// a default-width instance and a 2-bit-counter instance in lockstep.
module tb_spike_dispatch;
  import spike_dispatch_pkg::*;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] tick_i = 8'h00;
  logic       next_tick = 1'b0;
  logic       spk_done = 1'b0;
  logic       FIFO_empty_i = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       ack = 1'b0;

  logic        FIFO_r_en_o, aer_req_o, dispatch_done_o;
  logic [7:0]  aer_addr_o, aer_tick_o;
  logic [15:0] event_count_o;
  logic        r_en2, req2, done2;
  logic [7:0]  addr2, tick2;
  logic [1:0]  cnt2;

  always #5 CLK = ~CLK;

  spike_dispatch #(.N(256), .CNT_W(16)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .start_i(start_i), .tick_i(tick_i),
    .next_tick_i(next_tick), .spikecore_done_i(spk_done),
    .FIFO_empty_i(FIFO_empty_i), .FIFO_r_en_o(FIFO_r_en_o),
    .FIFO_r_data_i(rdata), .aer_req_o(aer_req_o),
    .aer_addr_o(aer_addr_o), .aer_tick_o(aer_tick_o),
    .aer_ack_i(ack), .event_count_o(event_count_o),
    .dispatch_done_o(dispatch_done_o)
  );

  spike_dispatch #(.N(256), .CNT_W(2)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .start_i(start_i), .tick_i(tick_i),
    .next_tick_i(next_tick), .spikecore_done_i(spk_done),
    .FIFO_empty_i(FIFO_empty_i), .FIFO_r_en_o(r_en2),
    .FIFO_r_data_i(rdata), .aer_req_o(req2),
    .aer_addr_o(addr2), .aer_tick_o(tick2),
    .aer_ack_i(ack), .event_count_o(cnt2),
    .dispatch_done_o(done2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic [7:0] pend_q[$];
  logic [7:0] fifo_q[$];
  aer_evt_t   exp_q[$];
  logic [7:0] exp_tick = 8'h00;
  int         n_exp = 0;
  int         ack_dly = 0;
  int         ack_hold = 1;
  bit         pop_empty = 1'b0;

  // FIFO model: pop on strobe, then accept pushes from the stimulus
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (!RSTN) begin
        fifo_q.delete();
        pend_q.delete();
        FIFO_empty_i = 1'b1;
        pop_empty = 1'b0;
      end else begin
        if (FIFO_r_en_o) begin
          pop_empty = (fifo_q.size() == 0);
          if (!pop_empty) rdata = fifo_q.pop_front();
        end
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        FIFO_empty_i = (fifo_q.size() == 0);
      end
    end
  end

  // AER target: ack after ack_dly cycles, hold for ack_hold cycles
  initial begin
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RSTN) begin
        ack = 1'b0;
        ph = 0;
      end else begin
        if (ph == 0 && aer_req_o) begin
          cnt = ack_dly;
          ph = 1;
        end
        if (ph == 1) begin
          if (cnt == 0) begin
            ack = 1'b1;
            cnt = ack_hold;
            ph = 2;
          end else begin
            cnt--;
          end
        end else if (ph == 2) begin
          cnt--;
          if (cnt == 0) begin
            ack = 1'b0;
            ph = 0;
          end
        end
      end
    end
  end

  // Monitor: pops expected events on each request and checks tick totals
  aer_evt_t cur;
  bit       prev_req = 1'b0;
  bit       prev_done = 1'b0;
  int       req_len = 0;
  int       ack_hi = 0;
  int       pops = 0;

  always @(negedge CLK) begin
    if (!RSTN) begin
      prev_req = 1'b0;
      prev_done = 1'b0;
      pops = 0;
      ack_hi = 0;
      req_len = 0;
    end else begin
      if (FIFO_r_en_o) begin
        pops++;
        chk("pop_from_empty", int'(pop_empty), 0);
      end
      if (aer_req_o && !prev_req) begin
        req_len = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 1, 0);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
          chk("evt_tick", aer_tick_o, int'(cur.tick));
          chk("req2", req2, 1);
          chk("evt_tick2", tick2, int'(cur.tick));
        end
      end
      if (aer_req_o) begin
        req_len++;
        chk("evt_addr", aer_addr_o, int'(cur.addr));
        chk("evt_addr2", addr2, int'(cur.addr));
      end
      if (!aer_req_o && prev_req) chk("req_len", req_len, ack_dly + 1);
      ack_hi = ack ? ack_hi + 1 : 0;
      if (ack_hi >= 2) chk("req_low_while_ack", aer_req_o, 0);
      if (dispatch_done_o && !prev_done) begin
        chk("event_count", event_count_o, (n_exp > 65535) ? 65535 : n_exp);
        chk("event_count_sat", cnt2, (n_exp > 3) ? 3 : n_exp);
        chk("all_events_sent", exp_q.size(), 0);
        chk("pops_per_tick", pops, n_exp);
        chk("done2", done2, 1);
        pops = 0;
      end
      prev_req = aer_req_o;
      prev_done = dispatch_done_o;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_tick(input logic [7:0] t);
    exp_tick = t;
    n_exp = 0;
  endtask

  task automatic push(input logic [7:0] a);
    aer_evt_t ev;
    ev.addr = 16'(a);
    ev.tick = exp_tick;
    pend_q.push_back(a);
    exp_q.push_back(ev);
    n_exp++;
  endtask

  task automatic start_pulse();
    tick_i = exp_tick;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    tick_i = 8'($urandom);
    chk("count_clear", event_count_o, 0);
    chk("count2_clear", cnt2, 0);
  endtask

  task automatic stray_start();
    tick_i = 8'($urandom);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic finish_tick(input int budget, input string nm);
    bit seen;
    seen = 1'b0;
    spk_done = 1'b1;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge CLK);
      seen = dispatch_done_o;
    end
    chk(nm, int'(seen), 1);
    cyc();
    spk_done = 1'b0;
    next_tick = 1'b1;
    cyc();
    next_tick = 1'b0;
    chk("done_released", dispatch_done_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    bit seen;

    RSTN = 1'b0;
    #1;
    chk("rst_req", aer_req_o, 0);
    chk("rst_ren", FIFO_r_en_o, 0);
    chk("rst_done", dispatch_done_o, 0);
    chk("rst_addr", aer_addr_o, 0);
    chk("rst_tick", aer_tick_o, 0);
    chk("rst_count", event_count_o, 0);
    repeat (3) cyc();
    RSTN = 1'b1;
    cyc();

    // three events, done already high: FIFO must drain first
    ack_dly = 0;
    ack_hold = 1;
    begin_tick(8'h05);
    push(8'd3);
    push(8'd7);
    push(8'd200);
    cyc();
    spk_done = 1'b1;
    start_pulse();
    finish_tick(100, "basic_done");

    // empty FIFO with done: finish within two cycles, no pops
    begin_tick(8'h11);
    spk_done = 1'b1;
    start_pulse();
    finish_tick(2, "empty_done_fast");

    // slow ack and long ack hold
    ack_dly = 10;
    ack_hold = 4;
    begin_tick(8'h22);
    push(8'd17);
    push(8'd99);
    cyc();
    start_pulse();
    finish_tick(200, "slow_ack_done");

    // long idle wait on an empty FIFO, then a single late spike
    ack_dly = 0;
    ack_hold = 1;
    begin_tick(8'h33);
    start_pulse();
    repeat (20) cyc();
    push(8'd42);
    repeat (8) cyc();
    finish_tick(100, "late_spike_done");

    // five events saturate the 2-bit counter; next tick restarts it
    ack_dly = 1;
    ack_hold = 2;
    begin_tick(8'h44);
    for (int i = 0; i < 5; i++) push(8'(10 + i));
    cyc();
    start_pulse();
    finish_tick(200, "sat_done");
    begin_tick(8'h45);
    push(8'd1);
    cyc();
    start_pulse();
    finish_tick(100, "sat_restart_done");

    // randomized ticks with stray start pulses mid-tick
    for (int r = 0; r < 8; r++) begin
      ack_dly = $urandom_range(0, 3);
      ack_hold = $urandom_range(1, 3);
      n = $urandom_range(0, 6);
      k = $urandom_range(0, n);
      begin_tick(8'($urandom));
      for (int i = 0; i < k; i++) push(8'($urandom));
      cyc();
      start_pulse();
      for (int i = k; i < n; i++) begin
        repeat ($urandom_range(0, 4)) cyc();
        push(8'($urandom));
        if ($urandom_range(0, 2) == 0) stray_start();
      end
      cyc();
      finish_tick(300, "rand_done");
    end

    // reset asserted in the middle of a request
    ack_dly = 30;
    ack_hold = 1;
    begin_tick(8'h66);
    push(8'd123);
    cyc();
    start_pulse();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      seen = aer_req_o;
    end
    chk("req_before_reset", int'(seen), 1);
    repeat (3) @(negedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    chk("async_req", aer_req_o, 0);
    chk("async_ren", FIFO_r_en_o, 0);
    chk("async_done", dispatch_done_o, 0);
    chk("async_addr", aer_addr_o, 0);
    chk("async_tick", aer_tick_o, 0);
    chk("async_count", event_count_o, 0);
    repeat (2) cyc();
    exp_q.delete();
    RSTN = 1'b1;
    ack_dly = 0;
    begin_tick(8'h77);
    push(8'd55);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("idle_no_pop", FIFO_r_en_o, 0);
      chk("idle_no_req", aer_req_o, 0);
    end
    cyc();
    start_pulse();
    finish_tick(100, "post_reset_done");

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
